ral_timer_regblock: RTL and testbench
=====================================

Name: ral_timer_regblock

Overview:
- Register-block slave that consumes the RAL bus (addr, wr_en, wdata, rdata) driven by the verification environment's driver stage.
- Holds a small memory-mapped register set controlling a prescaled, auto-reloading down-counter timer with an interrupt.
- It is the DUT behind the RAL model; every register below is mirrored in the RAL register model.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the block; must be 32-byte aligned.
- ID_VALUE, 32'h5241_4C01, constant returned by the ID register.

Ports:
- clk  input  1  clock; all sequential logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address; addr[1:0] ignored.
- wr_en  input  1  1 = write cycle, 0 = read cycle.
- wdata  input  32  write data, sampled when wr_en=1.
- rdata  output  32  registered read data.
- irq  output  1  interrupt, level, active-high.

Behaviour:
- Decode: the block is selected when addr[31:5] == BASE_ADDR[31:5]. The register offset is addr[4:2].
- Register map (offset, access, fields):
  - 0x00 CTRL, RW: [0] enable, [1] irq_en, [15:8] prescale; other bits read 0.
  - 0x04 LOAD, RW, 32 bits.
  - 0x08 COUNT, RO: current counter value.
  - 0x0C INTR_STAT, W1C: [0] expired, [1] overrun.
  - 0x10 ID, RO: ID_VALUE.
  - 0x14-0x1C: unmapped.
- Reset (reset=0, asynchronous): CTRL, LOAD, COUNT, INTR_STAT, the prescaler, rdata and irq all go to 0 immediately. Reset in mid-count discards all state. The first posedge after reset deasserts behaves as a normal cycle.
- Write (wr_en=1, selected, mapped): the register updates at that posedge.
  - Writes to RO registers, unmapped offsets, or unselected addresses are ignored with no error.
  - INTR_STAT write: each bit written 1 clears that bit; bits written 0 are unchanged.
- Read (wr_en=0): at the posedge, rdata <= value of the addressed register as it was before that edge. Latency is 1 cycle: data is valid on the edge after addr is presented.
  - Unselected or unmapped address: rdata <= 0.
  - During write cycles rdata holds its previous value.
  - Reads have no side effects.
- Prescaler: an 8-bit counter that runs only while enable=1.
  - tick = (prescaler == prescale). On tick the prescaler goes to 0; otherwise it increments.
- Counter, on tick:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: COUNT <= LOAD and expired <= 1. If expired was already 1, overrun <= 1 as well.
- Timer period = (LOAD+1)*(prescale+1) cycles. With LOAD=0 and prescale=0 the timer expires every cycle.
- Enable transitions:
  - A CTRL write taking enable 0->1 sets COUNT <= LOAD (the value before the edge) and prescaler <= 0. No tick occurs that cycle.
  - A CTRL write with enable already 1 does not reload.
  - enable 1->0 freezes COUNT and the prescaler at their current values.
- LOAD write while running: takes effect at the next reload only. If it lands in the same cycle as a reload, the old LOAD value is used.
- Simultaneous INTR_STAT W1C and hardware set of the same bit: set wins (bit = 1).
- irq is registered: irq <= irq_en & (expired | overrun). It therefore lags the status change by 1 cycle.

Test Plan:
- Reset/ID: assert reset, release, read 0x10 -> rdata = 32'h5241_4C01 one cycle later. Read 0x00/0x04/0x08/0x0C -> 0.
- RW/RO/unmapped:
  - Write 0x04 = 32'hDEAD_BEEF, read back -> DEAD_BEEF.
  - Write 0x08 = 5 -> COUNT stays 0.
  - Write/read 0x18 -> 0.
  - Write CTRL = 32'hFFFF_FFFF -> CTRL reads 32'h0000_FF03.
- Timer period: LOAD=3, CTRL prescale=1, enable=1, irq_en=1 -> expired sets exactly 8 cycles after the enabling write edge, and irq rises 1 cycle later. COUNT reads 3,3,2,2,1,1,0,0,3.
- W1C and overrun:
  - Let expired set, then let a second expiry occur without clearing -> INTR_STAT = 0x3.
  - Write 0x0C = 0x1 -> INTR_STAT = 0x2 and irq stays 1.
  - Write 0x0C = 0x2 -> irq drops.
  - W1C in the same cycle as an expiry -> expired remains 1.
- Freeze/reload: disable mid-count at COUNT=2 -> COUNT holds 2 for 10 cycles. Re-enable -> COUNT reloads to LOAD.
- Async reset mid-operation: assert reset between clock edges while running with irq=1 -> irq, rdata and COUNT go to 0 before the next posedge.

Source files
------------

// File: rtl/ral_timer_regblock.sv
// rtl/ral_timer_regblock.sv - memory-mapped prescaled auto-reload down-counter timer with interrupt
module ral_timer_regblock #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = 32'h5241_4C01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_LOAD = 3'd1;
  localparam logic [2:0] OFF_CNT  = 3'd2;
  localparam logic [2:0] OFF_STAT = 3'd3;
  localparam logic [2:0] OFF_ID   = 3'd4;

  logic        enable, irq_en;
  logic [7:0]  prescale, psc;
  logic [31:0] load, count;
  logic        expired, overrun;

  logic        sel;
  logic [2:0]  off;
  logic        wr_ctrl, wr_load, wr_stat;
  logic        tick, expire, start;
  logic [1:0]  clr;
  logic [31:0] rd_val;
  logic        unused_addr_lsbs;

  assign sel              = (addr[31:5] == BASE_ADDR[31:5]);
  assign off              = addr[4:2];
  assign unused_addr_lsbs = ^addr[1:0];

  assign wr_ctrl = wr_en && sel && (off == OFF_CTRL);
  assign wr_load = wr_en && sel && (off == OFF_LOAD);
  assign wr_stat = wr_en && sel && (off == OFF_STAT);

  // tick is qualified by the pre-edge enable, so the enabling write itself never ticks
  assign tick   = enable && (psc == prescale);
  assign expire = tick && (count == 32'd0);
  assign start  = wr_ctrl && !enable && wdata[0];
  assign clr    = wr_stat ? wdata[1:0] : 2'b00;

  always_comb begin
    rd_val = 32'd0;
    if (sel) begin
      case (off)
        OFF_CTRL: rd_val = {16'd0, prescale, 6'd0, irq_en, enable};
        OFF_LOAD: rd_val = load;
        OFF_CNT:  rd_val = count;
        OFF_STAT: rd_val = {30'd0, overrun, expired};
        OFF_ID:   rd_val = ID_VALUE;
        default:  rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= 8'd0;
      psc      <= 8'd0;
      load     <= 32'd0;
      count    <= 32'd0;
      expired  <= 1'b0;
      overrun  <= 1'b0;
      rdata    <= 32'd0;
      irq      <= 1'b0;
    end else begin
      if (start) begin
        count <= load;
        psc   <= 8'd0;
      end else if (tick) begin
        psc   <= 8'd0;
        count <= expire ? load : count - 32'd1;
      end else if (enable) begin
        psc <= psc + 8'd1;
      end

      if (wr_ctrl) begin
        enable   <= wdata[0];
        irq_en   <= wdata[1];
        prescale <= wdata[15:8];
      end
      if (wr_load) load <= wdata;

      // hardware set takes priority over a same-cycle W1C
      expired <= (expired & ~clr[0]) | expire;
      overrun <= (overrun & ~clr[1]) | (expire & expired);
      irq     <= irq_en & (expired | overrun);

      if (!wr_en) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_ral_timer_regblock.sv
// tb/tb_ral_timer_regblock.sv - scoreboard bench for ral_timer_regblock against a behavioural model
module tb_ral_timer_regblock;

  localparam logic [31:0] BASE = 32'h4000_0040;
  localparam logic [31:0] IDV  = 32'h5241_4C01;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  ral_timer_regblock #(.BASE_ADDR(BASE), .ID_VALUE(IDV)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        irq;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: register fields as the programmer sees them
  bit          m_en, m_ie, m_exp, m_ovr, m_irq;
  int unsigned m_ps, m_pre;
  logic [31:0] m_load, m_count, m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (a[4:2])
      3'd0: return (m_ps << 8) | (m_ie << 1) | m_en;
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return (m_ovr << 1) | m_exp;
      3'd4: return IDV;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_will_expire();
    return m_en && (m_pre == m_ps) && (m_count == 0);
  endfunction

  task automatic model_cycle(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit          sel, tick, fired, was_exp, was_en;
    int unsigned off;
    logic [31:0] old_load;
    if (rst) begin
      {m_en, m_ie, m_exp, m_ovr, m_irq} = '0;
      m_ps = 0; m_pre = 0; m_load = 0; m_count = 0; m_rdata = 0;
      return;
    end
    sel = (a[31:5] == BASE[31:5]);
    off = a[4:2];
    if (!w) m_rdata = m_read(a);
    m_irq    = m_ie && (m_exp || m_ovr);
    was_exp  = m_exp;
    was_en   = m_en;
    old_load = m_load;
    tick  = m_en && (m_pre == m_ps);
    fired = tick && (m_count == 0);
    if (tick) begin
      m_pre   = 0;
      m_count = (m_count == 0) ? old_load : m_count - 1;
    end else if (m_en) begin
      m_pre = (m_pre + 1) % 256;
    end
    if (w && sel && off == 3) begin
      if (d[0]) m_exp = 0;
      if (d[1]) m_ovr = 0;
    end
    if (fired) begin
      m_exp = 1;
      if (was_exp) m_ovr = 1;
    end
    if (w && sel && off == 0) begin
      if (!was_en && d[0]) begin
        m_count = old_load;
        m_pre   = 0;
      end
      m_en = d[0];
      m_ie = d[1];
      m_ps = d[15:8];
    end
    if (w && sel && off == 1) m_load = d;
  endtask

  task automatic cyc(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    reset = !rst;
    wr_en = w;
    addr  = a;
    wdata = d;
    model_cycle(rst, w, a, d);
    e.rdata = m_rdata;
    e.irq   = m_irq;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] off);
    cyc(0, 0, BASE | 32'(off), 32'd0);
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    cyc(0, 1, BASE | 32'(off), d);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("irq", {31'd0, irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin : driver
    int guard;
    repeat (3) cyc(1, 0, BASE, 0);

    rd(5'h10); rd(5'h00); rd(5'h04); rd(5'h08); rd(5'h0C);
    wr(5'h04, 32'hDEAD_BEEF); rd(5'h04);
    wr(5'h08, 32'd5); rd(5'h08);
    wr(5'h18, 32'h1234_5678); rd(5'h18);
    cyc(0, 0, 32'h0000_0010, 0);
    wr(5'h00, 32'hFFFF_FFFF); rd(5'h00);
    wr(5'h00, 32'h0);

    wr(5'h04, 32'd3);
    wr(5'h00, 32'h0000_0103);
    repeat (9) rd(5'h08);
    repeat (20) rd(5'h0C);
    wr(5'h0C, 32'h1); rd(5'h0C); rd(5'h0C);
    wr(5'h0C, 32'h2); rd(5'h0C); rd(5'h0C);

    guard = 0;
    while (!m_will_expire() && guard < 64) begin rd(5'h08); guard++; end
    chk("expire_wait", 32'(guard < 64), 32'd1);
    wr(5'h0C, 32'h1); rd(5'h0C);

    guard = 0;
    while (!(m_count == 2 && m_pre != m_ps) && guard < 64) begin rd(5'h08); guard++; end
    chk("count2_wait", 32'(guard < 64), 32'd1);
    wr(5'h00, 32'h0000_0102);
    repeat (10) rd(5'h08);
    wr(5'h00, 32'h0000_0103);
    rd(5'h08); rd(5'h08);

    guard = 0;
    while (!m_irq && guard < 64) begin rd(5'h04); guard++; end
    rd(5'h10);
    chk("irq_wait", 32'(guard < 64), 32'd1);
    @(posedge clk);
    #3;
    chk("irq_before_reset", {31'd0, irq}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_rdata", rdata, 32'd0);
    model_cycle(1, 0, 0, 0);
    cyc(1, 0, BASE | 32'h8, 0);
    rd(5'h08); rd(5'h00); rd(5'h0C);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, d;
      logic [4:0]  off;
      bit          w;
      off = 5'($urandom_range(0, 7) << 2) | 5'($urandom_range(0, 3));
      a   = BASE | 32'(off);
      if ($urandom_range(0, 7) == 0) a = a ^ (32'd1 << $urandom_range(5, 31));
      w = ($urandom_range(0, 2) == 0);
      case (off[4:2])
        3'd0: d = {16'($urandom), 8'($urandom_range(0, 3)), 6'($urandom), 2'($urandom)};
        3'd1: d = 32'($urandom_range(0, 6));
        default: d = $urandom;
      endcase
      cyc(0, w, a, d);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
    #4;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
